// File: rtl/bit_collector_pkg.sv
// -----------------------------------------------------------------------------
// bit_collector_pkg
//   Types and helpers used by the serial-to-parallel bit collector.
//   - state_e     : collector control state. The 2-bit encoding is fixed
//                   (IDLE=0, SHIFT=1, FULL=2) so that waveforms and any
//                   external decode agree with the RTL.
//   - cnt_width() : width of the bit counter for a given word size.
// -----------------------------------------------------------------------------
package bit_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no bits held
    ST_SHIFT = 2'd1,  // 1 .. Size-1 bits held
    ST_FULL  = 2'd2   // complete word held, waiting for ready_i
  } state_e;

  // Smallest width that can hold every count from 0 to size inclusive.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage : bit_collector_pkg

// File: rtl/bit_collector_shift_in_reg.sv
// -----------------------------------------------------------------------------
// shift_in_reg
//   Size-bit right-shift register. New bits enter at the MSB, so after Size
//   shifts the first bit received sits at bit 0 (LSB-first serial order).
//
// Ports
//   clock       : rising-edge clock
//   reset       : asynchronous, active-high; clears the register
//   clear_i     : synchronous clear (priority over shift_en_i)
//   shift_en_i  : shift bit_i in at the MSB this cycle
//   bit_i       : serial data bit
//   data_o      : current register contents
// -----------------------------------------------------------------------------
module shift_in_reg
  import bit_collector_pkg::*;
#(
  parameter int Size = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            shift_en_i,
  input  logic            bit_i,
  output logic [Size-1:0] data_o
);

  logic [Size-1:0] data_q;
  logic [Size-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = '0;
    end else if (shift_en_i) begin
      data_d = {bit_i, data_q[Size-1:1]};
    end
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop; blocking here would create ordering
  // dependent simulation and a mismatch against synthesized hardware.
  // The word is a plain register (not a memory), so resetting it is cheap and
  // gives a deterministic data_o out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule : shift_in_reg

// File: rtl/bit_collector.sv
// -----------------------------------------------------------------------------
// bit_collector
//   Serial-to-parallel collector. Assembles Size valid bits (LSB first) into
//   a word, presents it with writeEn_o and holds it until ready_i accepts it.
//   A transfer and the first bit of the next word may share a cycle, so a
//   continuous bit stream is collected with no bubbles when ready_i is high.
//
// Ports
//   clock       : sole clock, rising edge
//   reset       : asynchronous, active-high
//   bit_i       : serial data bit (LSB of the word first)
//   bitValid_i  : bit_i is valid this cycle
//   flush_i     : synchronous abort of partial/held word; clears overflow
//   ready_i     : downstream accepts the presented word
//   data_o      : assembled word (partial contents outside FULL)
//   writeEn_o   : data_o holds a complete word
//   busy_o      : a partial or held word exists
//   overflow_o  : sticky; a bit arrived while a word was held and not accepted
// -----------------------------------------------------------------------------
module bit_collector
  import bit_collector_pkg::*;
#(
  parameter int Size = 8  // legal range 2..64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            bit_i,
  input  logic            bitValid_i,
  input  logic            flush_i,
  input  logic            ready_i,
  output logic [Size-1:0] data_o,
  output logic            writeEn_o,
  output logic            busy_o,
  output logic            overflow_o
);

  localparam int CntW = cnt_width(Size);

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            write_en_q, write_en_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;

  logic            shift_en;
  logic            clear;
  logic            last_bit;

  // The bit being sampled now completes the word.
  assign last_bit = (count_q == CntW'(Size - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first; without
  // it a path that skips an assignment would infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    write_en_d = write_en_q;
    overflow_d = overflow_q;
    shift_en   = 1'b0;
    clear      = 1'b0;

    if (flush_i) begin
      // Flush wins over everything; any same-cycle bit is discarded.
      state_d    = ST_IDLE;
      count_d    = '0;
      write_en_d = 1'b0;
      overflow_d = 1'b0;
      clear      = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_SHIFT: begin
          if (bitValid_i) begin
            shift_en = 1'b1;
            if (last_bit) begin
              state_d    = ST_FULL;
              count_d    = CntW'(Size);
              write_en_d = 1'b1;
            end else begin
              state_d = ST_SHIFT;
              count_d = count_q + CntW'(1);
            end
          end
        end

        ST_FULL: begin
          if (ready_i) begin
            // Transfer on this edge. A same-cycle bit starts the next word;
            // shifting it in at the MSB pushes out the word just accepted.
            write_en_d = 1'b0;
            if (bitValid_i) begin
              shift_en = 1'b1;
              state_d  = ST_SHIFT;
              count_d  = CntW'(1);
            end else begin
              state_d = ST_IDLE;
              count_d = '0;
            end
          end else if (bitValid_i) begin
            // Word not accepted: the incoming bit is dropped, data holds.
            overflow_d = 1'b1;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          count_d    = '0;
          write_en_d = 1'b0;
        end
      endcase
    end

    // busy_o is a registered decode of the next state so it lines up with
    // state_q without a combinational path to the output.
    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      write_en_q <= write_en_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data path
  // ---------------------------------------------------------------------------
  shift_in_reg #(
    .Size (Size)
  ) u_shift_in_reg (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (clear),
    .shift_en_i (shift_en),
    .bit_i      (bit_i),
    .data_o     (data_o)
  );

  assign writeEn_o  = write_en_q;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;

endmodule : bit_collector

// File: doc/bit_collector.md
BIT_COLLECTOR -- requirements
Module: bit_collector

Interface
REQ-001 SHALL have parameter Size, default 8: output word width in bits; legal range 2..64.
REQ-002 SHALL have port clock, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port bit_i, input, 1: serial data bit; LSB of the word arrives first.
REQ-005 SHALL have port bitValid_i, input, 1: bit_i is valid this cycle.
REQ-006 SHALL have port flush_i, input, 1: synchronous abort of the partial or held word.
REQ-007 SHALL have port ready_i, input, 1: downstream accepts the presented word; tie high when driving a plain write-enabled register.
REQ-008 SHALL have port data_o, output, Size: assembled word.
REQ-009 SHALL have port writeEn_o, output, 1: data_o holds a complete word (valid).
REQ-010 SHALL have port busy_o, output, 1: a partial or held word exists.
REQ-011 SHALL have port overflow_o, output, 1: sticky flag; a bit was dropped.

Function
REQ-012 SHALL implement states IDLE (no bits), SHIFT (1..Size-1 bits held) and FULL (complete word held).
REQ-013 SHALL, in IDLE or SHIFT with bitValid_i=1, shift bit_i in at the MSB, shift the register right and increment the count.
REQ-014 SHALL enter FULL on the edge that samples the Size-th bit; writeEn_o high from the following cycle (latency 1 cycle from last bit sample).
REQ-015 SHALL, in FULL, hold data_o and writeEn_o stable until ready_i=1 is sampled; the transfer occurs on that edge.
REQ-016 SHALL, on a transfer with bitValid_i=1 in the same cycle, take that bit as bit 0 of the next word and go to SHIFT with count 1, adding zero bubbles.
REQ-017 SHALL, on a transfer with bitValid_i=0, go to IDLE with count 0.
REQ-018 SHALL, in FULL with ready_i=0 and bitValid_i=1, drop the bit, leave data_o unchanged and set overflow_o from the next cycle.
REQ-019 SHALL keep overflow_o set until reset or flush_i.
REQ-020 SHALL, on flush_i=1, go to IDLE, clear the count, data_o, writeEn_o and overflow_o, and discard any same-cycle bit; flush_i has priority over all other inputs except reset.
REQ-021 SHALL drive busy_o high exactly when the state is not IDLE (registered state decode).
REQ-022 SHALL size the counter to clog2(Size+1) bits; the count never exceeds Size and never wraps.
REQ-023 SHALL present the partial shift contents on data_o outside FULL; these are don't-care to consumers when writeEn_o=0.

Reset
REQ-024 SHALL, on reset=1, immediately and without a clock edge, force state IDLE, count 0, data_o 0, writeEn_o 0, busy_o 0 and overflow_o 0.
REQ-025 SHALL abandon any partial or held word on reset mid-operation; the first Size valid bits after release form a fresh word.

Structure
REQ-026 SHALL place the state typedef and encodings (IDLE=0, SHIFT=1, FULL=2, 2 bits) in shared package bit_collector_pkg.
REQ-027 SHALL separate the data path into a single sub-module shift_in_reg (Size-bit right-shift register with shift-enable and clear); control stays in bit_collector.

Verification (Size=8)
REQ-028 SHALL test: reset, ready_i=1, bits 1,0,1,1,0,0,0,0 on consecutive cycles -> next cycle data_o=8'h0D, writeEn_o=1 for exactly 1 cycle, then busy_o=0.
REQ-029 SHALL test: word 8'hA5 collected with ready_i=0 for 5 cycles -> writeEn_o high and data_o=8'hA5 stable for all 5; ready_i=1 -> writeEn_o low the next cycle.
REQ-030 SHALL test: 16 continuous valid bits forming 8'h3C then 8'hC3, ready_i=1 -> two writeEn_o pulses exactly 8 cycles apart, correct values, overflow_o=0.
REQ-031 SHALL test: FULL holding 8'h5A, ready_i=0, one valid bit -> overflow_o=1 next cycle, data_o still 8'h5A; flush_i -> overflow_o=0, busy_o=0, writeEn_o=0.
REQ-032 SHALL test: flush_i together with bitValid_i after 3 bits -> busy_o=0; the next 8 bits of 8'hFF -> data_o=8'hFF.
REQ-033 SHALL test: reset asserted between edges after 5 bits -> all outputs 0 before the next edge; after release, 8 bits of 8'h81 -> data_o=8'h81.
